// File: rtl/ioctl_mem_upload.sv
// ioctl_mem_upload: answers MiST ioctl upload reads by fetching bytes from a synchronous RAM read port.
module ioctl_mem_upload #(
    parameter int AW = 15,
    parameter logic [26:0] BASE = 27'h0,
    parameter logic [26:0] SIZE = 27'h8000,
    parameter bit WIDE = 1'b1,
    parameter logic [7:0] FILL = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [26:0]   ioctl_addr,
    input  logic          ioctl_rd,
    output logic [15:0]   ioctl_din,
    output logic          ioctl_wait,
    output logic          mem_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q
);
    localparam logic [2:0] IDLE = 3'd0, RD0 = 3'd1, CAP0 = 3'd2, RD1 = 3'd3, CAP1 = 3'd4;
    logic [2:0] state;
    logic [AW-1:0] addr;
    logic [7:0] lo;
    logic hit;
    logic [AW-1:0] a;
    // 28-bit compare so BASE+SIZE cannot overflow the window test
    assign hit = ({1'b0, ioctl_addr} >= {1'b0, BASE}) &&
                 ({1'b0, ioctl_addr} < ({1'b0, BASE} + {1'b0, SIZE}));
    assign a = AW'(ioctl_addr - BASE) & ~AW'(WIDE);
    assign mem_busy = ioctl_upload;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr <= '0;
            lo <= '0;
            ioctl_din <= '0;
            ioctl_wait <= 1'b0;
            mem_addr <= '0;
            mem_rd <= 1'b0;
        end else if (!ioctl_upload) begin
            state <= IDLE;
            ioctl_wait <= 1'b0;
            mem_rd <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ioctl_rd) begin
                    if (hit) begin
                        addr <= a;
                        mem_addr <= a;
                        mem_rd <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state <= RD0;
                    end else begin
                        ioctl_din <= {(WIDE ? FILL : 8'h00), FILL};
                    end
                end
                RD0: begin
                    mem_rd <= 1'b0;
                    state <= CAP0;
                end
                CAP0: if (WIDE) begin
                    lo <= mem_q;
                    mem_addr <= addr + AW'(1);
                    mem_rd <= 1'b1;
                    state <= RD1;
                end else begin
                    ioctl_din <= {8'h00, mem_q};
                    ioctl_wait <= 1'b0;
                    state <= IDLE;
                end
                RD1: begin
                    mem_rd <= 1'b0;
                    state <= CAP1;
                end
                CAP1: begin
                    ioctl_din <= {mem_q, lo};
                    ioctl_wait <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ioctl_mem_upload.sv
// tb_ioctl_mem_upload: random upload reads on 16-bit and 8-bit instances against a byte-array model.
module tb_ioctl_mem_upload;
    logic clk = 1'b0, reset = 1'b1, upload = 1'b0, rd = 1'b0;
    logic [26:0] addr = '0;
    logic [15:0] din_w, din_n;
    logic wait_w, wait_n, busy_w, busy_n, mem_rd_w, mem_rd_n;
    logic [14:0] mem_addr_w, mem_addr_n;
    logic [7:0] q_w = '0, q_n = '0;
    logic [7:0] mem [0:32767];
    int nrd_w = 0, nrd_n = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ioctl_mem_upload #(.WIDE(1'b1)) dut_w (
        .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_addr(addr), .ioctl_rd(rd),
        .ioctl_din(din_w), .ioctl_wait(wait_w), .mem_busy(busy_w), .mem_addr(mem_addr_w),
        .mem_rd(mem_rd_w), .mem_q(q_w));
    ioctl_mem_upload #(.WIDE(1'b0)) dut_n (
        .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_addr(addr), .ioctl_rd(rd),
        .ioctl_din(din_n), .ioctl_wait(wait_n), .mem_busy(busy_n), .mem_addr(mem_addr_n),
        .mem_rd(mem_rd_n), .mem_q(q_n));

    always @(posedge clk) begin
        if (mem_rd_w) begin
            q_w <= mem[mem_addr_w];
            nrd_w <= nrd_w + 1;
        end
        if (mem_rd_n) begin
            q_n <= mem[mem_addr_n];
            nrd_n <= nrd_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [26:0] ad, input bit extra);
        logic h;
        logic [14:0] a;
        logic [15:0] ew, en;
        int cw, cn;
        h = ad < 27'h8000;
        a = ad[14:0] & 15'h7FFE;
        ew = h ? {mem[a | 15'd1], mem[a]} : 16'hFFFF;
        en = h ? {8'h00, mem[ad[14:0]]} : 16'h00FF;
        cw = nrd_w;
        cn = nrd_n;
        addr = ad;
        rd = 1'b1;
        tick();
        rd = extra && h;
        if (extra && h) addr = 27'($urandom_range(0, 'h7FFF));
        chk("wait0_w", wait_w, h);
        chk("wait0_n", wait_n, h);
        if (!h) begin
            chk("din_miss_w", din_w, ew);
            chk("din_miss_n", din_n, en);
        end else begin
            chk("maddr0_w", mem_addr_w, a);
            chk("mrd0_w", mem_rd_w, 1);
            chk("maddr0_n", mem_addr_n, ad[14:0]);
            for (int e = 1; e <= 4; e++) begin
                tick();
                rd = 1'b0;
                if (e == 2) begin
                    chk("din_n", din_n, en);
                    chk("wait_n", wait_n, 0);
                    chk("maddr1_w", mem_addr_w, a | 15'd1);
                end
                chk("wait_w", wait_w, e < 4);
            end
            chk("din_w", din_w, ew);
        end
        chk("nrd_w", nrd_w - cw, h ? 2 : 0);
        chk("nrd_n", nrd_n - cn, h ? 1 : 0);
    endtask

    initial begin
        logic [15:0] prev;
        int cw, cn;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        #1;
        chk("rst_din_w", din_w, 0);
        chk("rst_wait_w", wait_w, 0);
        chk("rst_mrd_w", mem_rd_w, 0);
        chk("rst_maddr_w", mem_addr_w, 0);
        chk("rst_din_n", din_n, 0);
        tick();
        reset = 1'b0;
        upload = 1'b1;
        tick();
        chk("busy_w", busy_w, 1);
        chk("busy_n", busy_n, 1);
        do_req(27'h0010, 1'b0);
        do_req(27'h0013, 1'b1);
        do_req(27'h8000, 1'b0);
        do_req(27'h00A5, 1'b0);
        do_req(27'h7FFF, 1'b0);
        do_req(27'h0000, 1'b1);
        do_req(27'h7FFFFFF, 1'b0);
        for (int i = 0; i < 60; i++)
            do_req($urandom_range(0, 3) == 0 ? 27'($urandom_range('h8000, 'hFFFF))
                                              : 27'($urandom_range(0, 'h7FFF)),
                   1'($urandom));
        // drop the session while the wide instance is in its second read
        prev = din_w;
        addr = 27'h0222;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        upload = 1'b0;
        tick();
        chk("drop_wait_w", wait_w, 0);
        chk("drop_mrd_w", mem_rd_w, 0);
        chk("drop_din_w", din_w, prev);
        chk("drop_busy_w", busy_w, 0);
        tick();
        chk("drop_din2_w", din_w, prev);
        cw = nrd_w;
        cn = nrd_n;
        addr = 27'h0100;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("noupl_wait_w", wait_w, 0);
        chk("noupl_wait_n", wait_n, 0);
        tick();
        chk("noupl_nrd_w", nrd_w - cw, 0);
        chk("noupl_nrd_n", nrd_n - cn, 0);
        upload = 1'b1;
        tick();
        do_req(27'h0456, 1'b0);
        // asynchronous reset while the wide instance sits in CAP0
        addr = 27'h0300;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_wait_w", wait_w, 0);
        chk("arst_mrd_w", mem_rd_w, 0);
        chk("arst_din_w", din_w, 0);
        chk("arst_maddr_w", mem_addr_w, 0);
        chk("arst_din_n", din_n, 0);
        tick();
        reset = 1'b0;
        tick();
        do_req(27'h1235, 1'b1);
        do_req(27'h7FFE, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ioctl_mem_upload.md
Name: ioctl_mem_upload

Overview:
- Serves host upload (readback) requests over the MiST ioctl interface. This is the read direction opposite to the ROM/RAM download path.
- On each host read request, fetches bytes from an on-chip synchronous RAM read port and returns them on ioctl_din, holding the host off with ioctl_wait.
- Used for hiscore/NVRAM save and ROM image verify.
- Sits between the ioctl bus and the memory's read port. The CPU-side address mux keys off mem_busy.

Parameters:
- AW, 15, memory address width in bytes.
- BASE, 27'h0, first ioctl byte address mapped to memory address 0.
- SIZE, 27'h8000, window size in bytes; must be even when WIDE=1.
- WIDE, 1, 1 = 16-bit words (two bytes per request); 0 = 8-bit (ioctl_din[15:8]=0).
- FILL, 8'hFF, byte returned for addresses outside the window.

Ports:
- clk_sys  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  host upload session active.
- ioctl_addr  in  27  host byte address of requested word/byte.
- ioctl_rd  in  1  one-cycle read request strobe.
- ioctl_din  out  16  returned data; low byte = even address.
- ioctl_wait  out  1  busy; host must not issue ioctl_rd while high.
- mem_busy  out  1  = ioctl_upload; CPU address mux selects mem_addr while high.
- mem_addr  out  AW  RAM read address.
- mem_rd  out  1  RAM read enable.
- mem_q  in  8  RAM data; valid one clk_sys after mem_addr/mem_rd are presented.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, mem_addr=0, mem_rd=0, state=IDLE, latched address=0.
- Window test: hit = (ioctl_addr >= BASE) && (ioctl_addr < BASE+SIZE).
- Offset: a = (ioctl_addr - BASE)[AW-1:0]. When WIDE=1, a[0] is forced to 0 (word-aligned; odd host address reads the containing word).
- States: IDLE, RD0, CAP0, RD1, CAP1. RD1 and CAP1 are used only when WIDE=1.
- IDLE:
  - ioctl_rd && ioctl_upload && hit: latch a, ioctl_wait<=1, go to RD0.
  - ioctl_rd && ioctl_upload && !hit: ioctl_din<={WIDE?FILL:8'h00, FILL} next edge, ioctl_wait stays 0, no memory access, stay in IDLE.
  - ioctl_rd with ioctl_upload=0: ignored.
- RD0: mem_addr=a, mem_rd=1 (registered outputs driven from state). Next state CAP0.
- CAP0:
  - WIDE=1: capture mem_q as low byte, go to RD1.
  - WIDE=0: ioctl_din<={8'h00, mem_q}, ioctl_wait<=0, go to IDLE.
- RD1: mem_addr=a+1, mem_rd=1. Next state CAP1.
- CAP1: ioctl_din<={mem_q, lo}, ioctl_wait<=0, go to IDLE.
- mem_rd is 1 only in RD0/RD1; mem_addr holds its last value otherwise.
- Latency, counted as clock edges after the edge that samples ioctl_rd: WIDE=1 → 4; WIDE=0 → 2. ioctl_din is valid and ioctl_wait is low on that edge.
- ioctl_rd arriving while ioctl_wait=1: ignored, no queueing.
- ioctl_upload falling mid-operation: state→IDLE, ioctl_wait<=0, ioctl_din unchanged, mem_rd<=0 on the next edge.
- Address wrap: a is masked to AW bits. No carry out of a+1 is possible because the window and alignment guarantee a+1 < SIZE.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).
- Back-to-back: a new ioctl_rd may be sampled on the edge after ioctl_wait falls. Sustained throughput is 1 word per 5 cycles (WIDE=1).

Test Plan:
- Reset, memory preloaded with byte(i) = i[7:0]. Upload active, ioctl_rd @ addr 0x0010, WIDE=1 → wait high 4 edges, mem_addr 0x0010 then 0x0011, ioctl_din=16'h1110, wait low.
- ioctl_rd @ odd addr 0x0013, WIDE=1 → mem reads 0x0012/0x0013, ioctl_din=16'h1312.
- ioctl_rd @ 0x8000 (outside window, BASE=0, SIZE=0x8000) → no mem_rd, wait never high, ioctl_din=16'hFFFF one edge later.
- WIDE=0 instance, ioctl_rd @ 0x00A5 → one mem read @ 0x00A5, 2-edge latency, ioctl_din=16'h00A5.
- Drop ioctl_upload during RD1 → next edge: wait=0, mem_rd=0, state IDLE, ioctl_din keeps its previous value. A following request with upload reasserted completes normally.
- Assert reset during CAP0 → ioctl_wait, mem_rd, ioctl_din go to 0 without a clock edge. A second ioctl_rd issued while wait=1 produces no extra memory read.
